alu_seq_ctrl: RTL and testbench

- Sequential controller wrapping the combinational ALU. It owns the accumulator register and the C/Z/S/V/P flag register.
- Accepts operation commands over a valid/ready interface and drives the ALU inputs.
- Repeats an operation cmd_rep+1 times, chaining the stored carry into addc/subc, then returns the result over a valid/ready response interface.
- Sits between the instruction decoder and the ALU; it is the only writer of accumulator and flags.

---
 rtl/alu_seq_ctrl_pkg.sv | 44 ++++
 rtl/alu_flag_reg.sv | 38 +++
 rtl/alu_seq_ctrl.sv | 146 ++++++++++++++
 tb/tb_alu_seq_ctrl.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/alu_seq_ctrl_pkg.sv
// Shared definitions for the ALU sequencer: opcodes, flag indices, FSM states and
// opcode classification helpers.
package alu_defs;

  localparam logic [3:0] OpMov  = 4'h0;
  localparam logic [3:0] OpAdd  = 4'h1;
  localparam logic [3:0] OpAddc = 4'h2;
  localparam logic [3:0] OpSub  = 4'h3;
  localparam logic [3:0] OpSubc = 4'h4;
  localparam logic [3:0] OpInc  = 4'h5;
  localparam logic [3:0] OpDec  = 4'h6;
  localparam logic [3:0] OpAnd  = 4'h7;
  localparam logic [3:0] OpOr   = 4'h8;
  localparam logic [3:0] OpXor  = 4'h9;
  localparam logic [3:0] OpNot  = 4'hA;

  // Bit positions inside the {C,Z,S,V,P} flag vector.
  typedef enum int unsigned {
    FlagP = 0,
    FlagV = 1,
    FlagS = 2,
    FlagZ = 3,
    FlagC = 4
  } flag_idx_e;

  typedef enum logic [1:0] {
    StIdle,
    StExec,
    StResp
  } state_e;

  function automatic logic is_arith_v(input logic [3:0] op);
    return (op == OpAdd) || (op == OpAddc) || (op == OpSub) || (op == OpSubc);
  endfunction

  function automatic logic is_arith_c(input logic [3:0] op);
    return is_arith_v(op) || (op == OpInc) || (op == OpDec);
  endfunction

  function automatic logic is_defined(input logic [3:0] op);
    return op <= OpNot;
  endfunction

endpackage

// File: rtl/alu_flag_reg.sv
// {C,Z,S,V,P} flag register; Z/S/P load on every commit, C and V only for the
// opcodes that define them.
module alu_flag_reg
  import alu_defs::*;
(
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       commit_i,
  input  logic [3:0] op_i,
  input  logic       alu_c_i,
  input  logic       alu_z_i,
  input  logic       alu_s_i,
  input  logic       alu_v_i,
  input  logic       alu_p_i,
  output logic [4:0] flags_o
);

  logic [4:0] flags_d, flags_q;

  always_comb begin
    flags_d = flags_q;
    if (commit_i) begin
      flags_d[FlagZ] = alu_z_i;
      flags_d[FlagS] = alu_s_i;
      flags_d[FlagP] = alu_p_i;
      if (is_arith_c(op_i)) flags_d[FlagC] = alu_c_i;
      if (is_arith_v(op_i)) flags_d[FlagV] = alu_v_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) flags_q <= '0;
    else         flags_q <= flags_d;
  end

  assign flags_o = flags_q;

endmodule

// File: rtl/alu_seq_ctrl.sv
// Sequencer around an external ALU: owns accumulator and flags, repeats a command
// cmd_rep+1 times. Optional perf counter behind ALU_SEQ_CTRL_PERF_EN.
module alu_seq_ctrl
  import alu_defs::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned REP_W = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [3:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_data,
  input  logic [REP_W-1:0] cmd_rep,
  input  logic             abort,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_acc,
  output logic [4:0]       rsp_flags,
  output logic             rsp_err,
  output logic [WIDTH-1:0] alu_data,
  output logic [WIDTH-1:0] alu_acc,
  output logic [3:0]       alu_oper,
  output logic             alu_carry_in,
  input  logic [WIDTH-1:0] alu_out,
  input  logic             alu_c,
  input  logic             alu_z,
  input  logic             alu_s,
  input  logic             alu_v,
  input  logic             alu_p
`ifdef ALU_SEQ_CTRL_PERF_EN
  , output logic [15:0]    perf_cnt
`endif
);

  state_e           state_d, state_q;
  logic [WIDTH-1:0] acc_d, acc_q;
  logic [WIDTH-1:0] data_d, data_q;
  logic [3:0]       op_d, op_q;
  logic [REP_W-1:0] cnt_d, cnt_q;
  logic             err_d, err_q;
  logic             commit;
  logic [4:0]       flags;

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    data_d    = data_q;
    op_d      = op_q;
    cnt_d     = cnt_q;
    err_d     = err_q;
    commit    = 1'b0;
    cmd_ready = 1'b0;
    rsp_valid = 1'b0;
    unique case (state_q)
      StIdle: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          op_d    = cmd_op;
          data_d  = cmd_data;
          cnt_d   = cmd_rep;
          state_d = StExec;
        end
      end
      StExec: begin
        if (abort) begin
          state_d = StIdle;
        end else if (!is_defined(op_q)) begin
          // Undefined opcodes burn one cycle and leave acc/flags untouched.
          err_d   = 1'b1;
          state_d = StResp;
        end else begin
          commit = 1'b1;
          acc_d  = alu_out;
          if (cnt_q == '0) state_d = StResp;
          else             cnt_d   = cnt_q - REP_W'(1);
        end
      end
      StResp: begin
        rsp_valid = 1'b1;
        if (rsp_ready) begin
          state_d = StIdle;
          err_d   = 1'b0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      acc_q   <= '0;
      data_q  <= '0;
      op_q    <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      data_q  <= data_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  alu_flag_reg u_flag_reg (
    .clk_i    (clk),
    .rst_ni   (rst_n),
    .commit_i (commit),
    .op_i     (op_q),
    .alu_c_i  (alu_c),
    .alu_z_i  (alu_z),
    .alu_s_i  (alu_s),
    .alu_v_i  (alu_v),
    .alu_p_i  (alu_p),
    .flags_o  (flags)
  );

  assign alu_oper     = op_q;
  assign alu_data     = data_q;
  assign alu_acc      = acc_q;
  assign alu_carry_in = flags[FlagC];
  assign rsp_acc      = acc_q;
  assign rsp_flags    = flags;
  assign rsp_err      = err_q;

`ifdef ALU_SEQ_CTRL_PERF_EN
  logic [15:0] perf_d, perf_q;

  always_comb begin
    perf_d = perf_q;
    if (commit && (perf_q != 16'hFFFF)) perf_d = perf_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) perf_q <= '0;
    else        perf_q <= perf_d;
  end

  assign perf_cnt = perf_q;
`endif

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Directed bench for alu_seq_ctrl with a behavioural 8-bit ALU closing the loop.
module tb_alu_seq_ctrl;
  import alu_defs::*;

  logic       clk;
  logic       rst_n;
  logic       cmd_valid, cmd_ready;
  logic [3:0] cmd_op;
  logic [7:0] cmd_data;
  logic [2:0] cmd_rep;
  logic       abort;
  logic       rsp_valid, rsp_ready;
  logic [7:0] rsp_acc;
  logic [4:0] rsp_flags;
  logic       rsp_err;
  logic [7:0] alu_data, alu_acc, alu_out;
  logic [3:0] alu_oper;
  logic       alu_carry_in;
  logic       alu_c, alu_z, alu_s, alu_v, alu_p;
`ifdef ALU_SEQ_CTRL_PERF_EN
  logic [15:0] perf_cnt;
`endif

  int nvec  = 0;
  int nfail = 0;

  alu_seq_ctrl #(.WIDTH(8), .REP_W(3)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_op       (cmd_op),
    .cmd_data     (cmd_data),
    .cmd_rep      (cmd_rep),
    .abort        (abort),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_acc      (rsp_acc),
    .rsp_flags    (rsp_flags),
    .rsp_err      (rsp_err),
    .alu_data     (alu_data),
    .alu_acc      (alu_acc),
    .alu_oper     (alu_oper),
    .alu_carry_in (alu_carry_in),
    .alu_out      (alu_out),
    .alu_c        (alu_c),
    .alu_z        (alu_z),
    .alu_s        (alu_s),
    .alu_v        (alu_v),
    .alu_p        (alu_p)
`ifdef ALU_SEQ_CTRL_PERF_EN
    , .perf_cnt   (perf_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference ALU: C is carry-out for add/inc, borrow for sub/dec; P set on even parity.
  always_comb begin
    logic [8:0] r9;
    r9    = 9'd0;
    alu_c = 1'b0;
    alu_v = 1'b0;
    case (alu_oper)
      OpMov:  r9 = {1'b0, alu_data};
      OpAdd:  r9 = {1'b0, alu_acc} + {1'b0, alu_data};
      OpAddc: r9 = {1'b0, alu_acc} + {1'b0, alu_data} + {8'd0, alu_carry_in};
      OpSub:  r9 = {1'b0, alu_acc} - {1'b0, alu_data};
      OpSubc: r9 = {1'b0, alu_acc} - {1'b0, alu_data} - {8'd0, alu_carry_in};
      OpInc:  r9 = {1'b0, alu_acc} + 9'd1;
      OpDec:  r9 = {1'b0, alu_acc} - 9'd1;
      OpAnd:  r9 = {1'b0, alu_acc & alu_data};
      OpOr:   r9 = {1'b0, alu_acc | alu_data};
      OpXor:  r9 = {1'b0, alu_acc ^ alu_data};
      OpNot:  r9 = {1'b0, ~alu_acc};
      default: r9 = 9'h0AA;
    endcase
    alu_out = r9[7:0];
    if (alu_oper inside {OpAdd, OpAddc, OpSub, OpSubc, OpInc, OpDec}) alu_c = r9[8];
    if (alu_oper inside {OpAdd, OpAddc})
      alu_v = (alu_acc[7] == alu_data[7]) && (r9[7] != alu_acc[7]);
    if (alu_oper inside {OpSub, OpSubc})
      alu_v = (alu_acc[7] != alu_data[7]) && (r9[7] != alu_acc[7]);
    alu_z = (r9[7:0] == 8'h00);
    alu_s = r9[7];
    alu_p = ~^r9[7:0];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge with the DUT idle; returns at the negedge after the accept edge.
  task automatic send(input string tag, input logic [3:0] op, input logic [7:0] d,
                      input logic [2:0] rep);
    check({tag, "_ready"}, 32'(cmd_ready), 32'd1);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_data  = d;
    cmd_rep   = rep;
    @(negedge clk);
    cmd_valid = 1'b0;
    cmd_op    = 4'h0;
    cmd_data  = 8'h00;
    cmd_rep   = 3'd0;
  endtask

  task automatic wait_rsp(input string tag, input int lat);
    int cyc = 0;
    while (rsp_valid !== 1'b1 && cyc < 64) begin
      @(negedge clk);
      cyc++;
    end
    check({tag, "_lat"}, 32'(cyc), 32'(lat));
  endtask

  task automatic consume();
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  task automatic run(input string tag, input logic [3:0] op, input logic [7:0] d,
                     input logic [2:0] rep, input int lat, input logic [7:0] exp_acc,
                     input logic [4:0] exp_flags);
    send(tag, op, d, rep);
    wait_rsp(tag, lat);
    check({tag, "_acc"}, 32'(rsp_acc), 32'(exp_acc));
    check({tag, "_flags"}, 32'(rsp_flags), 32'(exp_flags));
    check({tag, "_err"}, 32'(rsp_err), 32'd0);
    consume();
  endtask

  initial begin
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = 4'h0; cmd_data = 8'h00; cmd_rep = 3'd0;
    abort = 1'b0; rsp_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_acc", 32'(rsp_acc), 32'h00);
    check("rst_flags", 32'(rsp_flags), 32'h00);
    check("rst_ready", 32'(cmd_ready), 32'd1);
    check("rst_valid", 32'(rsp_valid), 32'd0);
    check("rst_err", 32'(rsp_err), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Reset asserted mid-EXEC: everything discarded, no response.
    send("mid", OpInc, 8'h00, 3'd7);
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_ready", 32'(cmd_ready), 32'd1);
    check("midrst_valid", 32'(rsp_valid), 32'd0);
    check("midrst_acc", 32'(rsp_acc), 32'h00);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("midrst_novalid", 32'(rsp_valid), 32'd0);

    // Signed overflow into 0x80.
    run("mov7f", OpMov, 8'h7F, 3'd0, 1, 8'h7F, 5'b00000);
    run("add01", OpAdd, 8'h01, 3'd0, 1, 8'h80, 5'b00110);

    // Repeated inc through wrap.
    run("movfe", OpMov, 8'hFE, 3'd0, 1, 8'hFE, 5'b00110);
    run("inc4",  OpInc, 8'h00, 3'd3, 4, 8'h02, 5'b00010);

    // Carry out of add feeds addc.
    run("movff", OpMov,  8'hFF, 3'd0, 1, 8'hFF, 5'b00111);
    run("addff", OpAdd,  8'h01, 3'd0, 1, 8'h00, 5'b11001);
    run("addc",  OpAddc, 8'h00, 3'd0, 1, 8'h01, 5'b00000);

    // Abort in the third EXEC cycle: two iterations committed, no response.
    run("mov00", OpMov, 8'h00, 3'd0, 1, 8'h00, 5'b01001);
    send("abt", OpInc, 8'h00, 3'd7);
    repeat (2) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abt_ready", 32'(cmd_ready), 32'd1);
    check("abt_valid", 32'(rsp_valid), 32'd0);
    check("abt_acc", 32'(rsp_acc), 32'h02);
    check("abt_flags", 32'(rsp_flags), 32'h00);
    repeat (3) @(negedge clk);
    check("abt_novalid", 32'(rsp_valid), 32'd0);
    check("abt_acc_hold", 32'(rsp_acc), 32'h02);

    // Undefined opcode with back-pressure; a competing command must not be taken.
    send("undef", 4'hF, 8'h55, 3'd5);
    wait_rsp("undef", 1);
    check("undef_err", 32'(rsp_err), 32'd1);
    cmd_valid = 1'b1;
    cmd_op    = OpInc;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("hold_valid", 32'(rsp_valid), 32'd1);
      check("hold_acc", 32'(rsp_acc), 32'h02);
      check("hold_flags", 32'(rsp_flags), 32'h00);
      check("hold_err", 32'(rsp_err), 32'd1);
      check("hold_ready", 32'(cmd_ready), 32'd0);
    end
    cmd_valid = 1'b0;
    cmd_op    = 4'h0;
    consume();
    check("post_valid", 32'(rsp_valid), 32'd0);
    check("post_err", 32'(rsp_err), 32'd0);
    check("post_ready", 32'(cmd_ready), 32'd1);
    check("post_acc", 32'(rsp_acc), 32'h02);

    // Borrow chaining through subc.
    run("mov00b", OpMov,  8'h00, 3'd0, 1, 8'h00, 5'b01001);
    run("sub01",  OpSub,  8'h01, 3'd0, 1, 8'hFF, 5'b10101);
    run("subc2",  OpSubc, 8'h00, 3'd1, 2, 8'hFE, 5'b00100);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
